atri_test_pattern: RTL
======================

Name: atri_test_pattern

Overview:
- Parametrised test-pattern source and loopback checker for bring-up of ATRI data paths.
- Drives NCH channels of WIDTH-bit pattern words over a valid/ready interface.
- Checks the returned words against a locally regenerated expected stream and accumulates saturating error and word counts.
- Sits between a DAQ data path under test and the control register block.

Parameters:
NCH, 4, number of channels, 1..8
WIDTH, 16, bits per channel word, 8..32
CNT_WIDTH, 32, width of error and word counters

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
enable_i  in  1  run request (level)
mode_i  in  2  0 counter, 1 walking-one, 2 PRBS7, 3 constant
seed_i  in  WIDTH  start value; sampled on IDLE->RUN
clear_i  in  1  clears counters and sticky flags
tx_dat_o  out  NCH*WIDTH  pattern words; channel k in bits [k*WIDTH +: WIDTH]
tx_valid_o  out  1  pattern word valid
tx_ready_i  in  1  sink accepts word
rx_dat_i  in  NCH*WIDTH  returned words
rx_valid_i  in  1  returned word valid
err_cnt_o  out  CNT_WIDTH  mismatched channel-words, saturating
err_flag_o  out  NCH  sticky per-channel mismatch
words_o  out  CNT_WIDTH  checked rx words, saturating
busy_o  out  1  high when not in IDLE

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Both generators are cleared.
- FSM states: IDLE, RUN, STOP.
  - IDLE->RUN: when enable_i=1. Latch mode_i and seed_i, load both generators.
  - RUN->STOP: when enable_i=0.
  - STOP->IDLE: when no tx word is pending. If tx_valid_o=1 && tx_ready_i=0, stay in STOP until the handshake completes.
- tx_valid_o rises the cycle after entering RUN.
- Once raised, tx_valid_o and tx_dat_o stay stable until tx_valid_o && tx_ready_i.
- tx generator advances on each handshake. A new word is presented the next cycle without a bubble.
- tx_valid_o falls the cycle after the handshake in STOP.
- Base word B per mode:
  - Counter: B=seed, then +1 mod 2^WIDTH; all-ones wraps to 0.
  - Walking-one: B=1, rotates left 1 bit per word; seed ignored.
  - PRBS7: polynomial x^7+x^6+1, one step per word, zero-extended to WIDTH. Loaded from seed[6:0]; an all-zero seed becomes 7'h7F.
  - Constant: B=seed always.
- Channel k word = B rotated left by k bits.
- Checker:
  - In RUN/STOP, each rx_valid_i compares all channels against the expected generator, then advances it.
  - Results are registered: counters and flags update 1 cycle after rx_valid_i.
  - rx_valid_i in IDLE is ignored.
- err_cnt_o adds the number of mismatching channels per rx word and saturates at all-ones.
- words_o increments by 1 per checked rx word and saturates.
- clear_i has priority over a same-cycle update: counters go to 0 and that cycle's result is dropped.
- mode_i/seed_i changes during RUN have no effect until the next start.
- rst_i mid-transfer aborts immediately with no drain.

Optional Feature:
- Macro: ATRI_TEST_PATTERN_PRBS_EN.
- Defined: PRBS7 mode as above.
- Undefined: PRBS logic is absent and mode 2 behaves as counter mode.

Decomposition:
- Shared package/include `atri_test_pattern_pkg`: mode encodings, PRBS7 taps and the zero-seed replacement value, FSM state encodings.
- Sub-module `atri_test_pattern_word`: load/advance generator for one base word, instantiated twice (tx and expected).

Test Plan:
- Counter, seed 16'hFFFE, tx_ready_i=1, loopback tx->rx: tx words FFFE, FFFF, 0000, 0001 on ch0; ch1 = 0xFFFD, ...; err_cnt_o=0; words_o=4 after 4 words.
- Walking-one: ch0 sequence 0001, 0002, ... 8000, 0001; ch3 first word 0008.
- Backpressure: tx_ready_i low 5 cycles mid-stream with enable_i dropped → tx_dat_o stable, busy_o stays 1 until handshake, then IDLE; no word lost.
- Error injection: flip bit 0 of ch2 on the 3rd rx word → err_cnt_o=1 and err_flag_o=4'b0100 one cycle later. clear_i asserted in the same cycle as a second error → counters read 0.
- Saturation: force CNT_WIDTH=4 and all channels corrupted → err_cnt_o sticks at 15.
- PRBS with macro on, seed 0: first word 7'h7F, period 127. With macro off, mode 2 yields counter output.

Source files
------------

// File: rtl/atri_test_pattern_pkg.sv
// Shared encodings for the ATRI test-pattern source/checker: pattern modes,
// FSM states and the PRBS7 helper used when ATRI_TEST_PATTERN_PRBS_EN is defined.
package atri_test_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_PRBS    = 2'd2,
    MODE_CONST   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // An all-zero PRBS7 state would lock up, so it is replaced on load.
  localparam logic [6:0] PRBS_ZERO_SEED = 7'h7F;

  // x^7 + x^6 + 1: feedback from state bits 6 and 5, shifted in at bit 0.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/atri_test_pattern_word.sv
// Base-word generator: loads from mode/seed on start and steps one word per advance.
// PRBS7 support only exists when ATRI_TEST_PATTERN_PRBS_EN is defined; otherwise mode 2 acts as counter.
module atri_test_pattern_word
  import atri_test_pattern_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] word_o
);

  mode_e            mode_q;
  mode_e            load_mode;
  logic [WIDTH-1:0] word_q;

  always_comb begin
    load_mode = mode_e'(mode_i);
`ifndef ATRI_TEST_PATTERN_PRBS_EN
    if (load_mode == MODE_PRBS) load_mode = MODE_COUNTER;
`endif
  end

  // NOTE: all state in always_ff uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= MODE_COUNTER;
      word_q <= '0;
    end else if (load_i) begin
      mode_q <= load_mode;
      case (load_mode)
        MODE_WALK: word_q <= WIDTH'(1);
`ifdef ATRI_TEST_PATTERN_PRBS_EN
        MODE_PRBS: word_q <= (seed_i[6:0] == 7'd0) ? WIDTH'(PRBS_ZERO_SEED) : WIDTH'(seed_i[6:0]);
`endif
        default:   word_q <= seed_i;
      endcase
    end else if (advance_i) begin
      case (mode_q)
        MODE_COUNTER: word_q <= word_q + WIDTH'(1);
        MODE_WALK:    word_q <= {word_q[WIDTH-2:0], word_q[WIDTH-1]};
`ifdef ATRI_TEST_PATTERN_PRBS_EN
        MODE_PRBS:    word_q <= WIDTH'(prbs7_step(word_q[6:0]));
`endif
        default:      word_q <= word_q;
      endcase
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/atri_test_pattern.sv
// ATRI test-pattern source and loopback checker with saturating error/word counters.
// Optional PRBS7 mode is enabled by defining ATRI_TEST_PATTERN_PRBS_EN.
module atri_test_pattern
  import atri_test_pattern_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     seed_i,
  input  logic                 clear_i,
  output logic [NCH*WIDTH-1:0] tx_dat_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  input  logic [NCH*WIDTH-1:0] rx_dat_i,
  input  logic                 rx_valid_i,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [NCH-1:0]       err_flag_o,
  output logic [CNT_WIDTH-1:0] words_o,
  output logic                 busy_o
);

  localparam int NW = $clog2(NCH + 1);

  state_e               state;
  logic                 tx_valid;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic [CNT_WIDTH-1:0] words;
  logic [NCH-1:0]       err_flag;
  logic [WIDTH-1:0]     tx_base;
  logic [WIDTH-1:0]     exp_base;
  logic [NCH-1:0]       mismatch;
  logic [NW-1:0]        n_mis;
  logic [CNT_WIDTH:0]   err_sum;
  logic                 start;
  logic                 tx_fire;
  logic                 rx_check;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w, input int k);
    logic [2*WIDTH-1:0] t;
    t = {w, w} << k;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  assign start    = (state == ST_IDLE) && enable_i;
  assign tx_fire  = tx_valid && tx_ready_i;
  assign rx_check = rx_valid_i && (state != ST_IDLE);

  atri_test_pattern_word #(.WIDTH(WIDTH)) u_tx_word (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start),
    .advance_i (tx_fire),
    .mode_i    (mode_i),
    .seed_i    (seed_i),
    .word_o    (tx_base)
  );

  atri_test_pattern_word #(.WIDTH(WIDTH)) u_exp_word (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start),
    .advance_i (rx_check),
    .mode_i    (mode_i),
    .seed_i    (seed_i),
    .word_o    (exp_base)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign tx_dat_o[k*WIDTH +: WIDTH] = rotl(tx_base, k);
    assign mismatch[k] = rx_dat_i[k*WIDTH +: WIDTH] != rotl(exp_base, k);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    n_mis = '0;
    for (int k = 0; k < NCH; k++) n_mis = n_mis + NW'(mismatch[k]);
    err_sum = {1'b0, err_cnt} + (CNT_WIDTH+1)'(n_mis);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      err_cnt  <= '0;
      words    <= '0;
      err_flag <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable_i) state <= ST_RUN;
        ST_RUN: begin
          tx_valid <= 1'b1;
          if (!enable_i) state <= ST_STOP;
        end
        ST_STOP: begin
          // Drain: leave only once no word is left waiting for the sink.
          if (!tx_valid || tx_ready_i) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (clear_i) begin
        err_cnt  <= '0;
        words    <= '0;
        err_flag <= '0;
      end else if (rx_check) begin
        err_cnt  <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        words    <= (&words) ? words : words + CNT_WIDTH'(1);
        err_flag <= err_flag | mismatch;
      end
    end
  end

  assign tx_valid_o = tx_valid;
  assign err_cnt_o  = err_cnt;
  assign words_o    = words;
  assign err_flag_o = err_flag;
  assign busy_o     = (state != ST_IDLE);

endmodule
